// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master nibble-bus arbiter.
// Widths are fixed here so the interface and the arbiter always agree.
package bus_arbiter_pkg;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 4;

  localparam logic RwWrite = 1'b1;
  localparam logic RwRead  = 1'b0;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StWait,
    StDone
  } state_e;

  // Request fields captured at grant time.
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } xfer_t;

  // The wait counter runs from WAIT_CYCLES-1 down to 0, so the WAIT state lasts exactly
  // WAIT_CYCLES cycles.
  function automatic logic [2:0] wait_load(int unsigned wait_cycles);
    return (wait_cycles > 0) ? 3'(wait_cycles - 1) : 3'd0;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side and bus-side signals of the arbiter, grouped into one interface.
// The slave modport is the arbiter's view; the master modport is the masters'/pads' view.
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  logic              m0_req;
  logic              m0_rw;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_rw;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] bus_addr;
  logic              bus_rw;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;

  logic              busy;
  logic              grant_id;

  modport slave (
    input  m0_req, m0_rw, m0_addr, m0_wdata,
    input  m1_req, m1_rw, m1_addr, m1_wdata,
    input  bus_rdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output bus_addr, bus_rw, bus_wdata,
    output busy, grant_id
  );

  modport master (
    output m0_req, m0_rw, m0_addr, m0_wdata,
    output m1_req, m1_rw, m1_addr, m1_wdata,
    output bus_rdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  bus_addr, bus_rw, bus_wdata,
    input  busy, grant_id
  );

endinterface

// File: rtl/bus_rr_pick.sv
// Combinational two-way round-robin picker: a lone requester wins outright,
// and on a tie the master that was not served last wins.
module bus_rr_pick (
  input  logic [1:0] req_i,
  input  logic       last_served_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  always_comb begin
    gnt_valid_o = |req_i;
    gnt_id_o    = 1'b0;
    case (req_i)
      2'b01:   gnt_id_o = 1'b0;
      2'b10:   gnt_id_o = 1'b1;
      2'b11:   gnt_id_o = ~last_served_i;
      default: gnt_id_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates the external nibble bus between two masters, one transaction per grant,
// sequenced IDLE -> ADDR -> WAIT (WAIT_CYCLES, 0..7, skipped if 0) -> DONE -> IDLE.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic          clk,
  input logic          rst,
  bus_arbiter_if.slave bus
);

  localparam logic [2:0] WaitLoad = wait_load(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  xfer_t             xfer_q, xfer_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic gnt_valid;
  logic gnt_id;
  logic capture;

  bus_rr_pick u_pick (
    .req_i         ({bus.m1_req, bus.m0_req}),
    .last_served_i (last_q),
    .gnt_valid_o   (gnt_valid),
    .gnt_id_o      (gnt_id)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    xfer_d   = xfer_q;
    grant_d  = grant_q;
    last_d   = last_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    capture  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          grant_d = gnt_id;
          if (gnt_id) begin
            xfer_d.rw    = bus.m1_rw;
            xfer_d.addr  = bus.m1_addr;
            xfer_d.wdata = bus.m1_wdata;
          end else begin
            xfer_d.rw    = bus.m0_rw;
            xfer_d.addr  = bus.m0_addr;
            xfer_d.wdata = bus.m0_wdata;
          end
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (WAIT_CYCLES > 0) begin
          cnt_d   = WaitLoad;
          state_d = StWait;
        end else begin
          capture = 1'b1;
          state_d = StDone;
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) begin
          capture = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StDone: begin
        last_d  = grant_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Read data is taken on the edge leaving the last ADDR/WAIT cycle, so it is
    // already valid during DONE when the ack is raised.
    if (capture && (xfer_q.rw == RwRead)) begin
      if (grant_q) begin
        rdata1_d = bus.bus_rdata;
      end else begin
        rdata0_d = bus.bus_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 3'd0;
      xfer_q   <= '0;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      xfer_q   <= xfer_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Outputs decode straight from state, so reset drops bus_rw without waiting for a clock.
  always_comb begin
    bus.busy      = (state_q != StIdle);
    bus.bus_rw    = (state_q != StIdle) && (xfer_q.rw == RwWrite);
    bus.bus_addr  = xfer_q.addr;
    bus.bus_wdata = xfer_q.wdata;
    bus.grant_id  = grant_q;
    bus.m0_ack    = (state_q == StDone) && !grant_q;
    bus.m1_ack    = (state_q == StDone) && grant_q;
    bus.m0_rdata  = rdata0_q;
    bus.m1_rdata  = rdata1_q;
  end

  a_ack_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(bus.m0_ack && bus.m1_ack));

  a_ack_single: assert property (@(posedge clk) disable iff (rst)
    (bus.m0_ack || bus.m1_ack) |=> !(bus.m0_ack || bus.m1_ack));

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (WAIT_CYCLES 2 and 0) checked every cycle against a
// transaction-level model, with directed scenarios followed by randomized traffic.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              req      [NI][2];
  logic              rw_in    [NI][2];
  logic [ADDR_W-1:0] addr_in  [NI][2];
  logic [DATA_W-1:0] wdata_in [NI][2];
  logic [DATA_W-1:0] rdata_in [NI];

  logic              ack      [NI][2];
  logic [DATA_W-1:0] rdata    [NI][2];
  logic [ADDR_W-1:0] bus_addr [NI];
  logic              bus_rw   [NI];
  logic [DATA_W-1:0] bus_wdata[NI];
  logic              busy     [NI];
  logic              grant_id [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    bus_arbiter_if bif ();

    assign bif.m0_req    = req[g][0];
    assign bif.m0_rw     = rw_in[g][0];
    assign bif.m0_addr   = addr_in[g][0];
    assign bif.m0_wdata  = wdata_in[g][0];
    assign bif.m1_req    = req[g][1];
    assign bif.m1_rw     = rw_in[g][1];
    assign bif.m1_addr   = addr_in[g][1];
    assign bif.m1_wdata  = wdata_in[g][1];
    assign bif.bus_rdata = rdata_in[g];

    assign ack[g][0]    = bif.m0_ack;
    assign ack[g][1]    = bif.m1_ack;
    assign rdata[g][0]  = bif.m0_rdata;
    assign rdata[g][1]  = bif.m1_rdata;
    assign bus_addr[g]  = bif.bus_addr;
    assign bus_rw[g]    = bif.bus_rw;
    assign bus_wdata[g] = bif.bus_wdata;
    assign busy[g]      = bif.busy;
    assign grant_id[g]  = bif.grant_id;

    bus_arbiter #(
      .WAIT_CYCLES ((g == 0) ? 2 : 0)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
    );
  end

  // Transaction-level model: a transaction occupies lat() consecutive cycles starting the
  // cycle after the grant; m_k counts how many of those cycles have elapsed.
  bit                m_active [NI];
  int                m_k      [NI];
  bit                m_gid    [NI];
  bit                m_rw     [NI];
  logic [ADDR_W-1:0] m_addr   [NI];
  logic [DATA_W-1:0] m_wdata  [NI];
  bit                m_last   [NI];
  logic [DATA_W-1:0] m_rdata  [NI][2];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic int lat(int i);
    return 2 + ((i == 0) ? 2 : 0);
  endfunction

  task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_active[i] = 1'b0;
      m_k[i]      = 0;
      m_gid[i]    = 1'b0;
      m_rw[i]     = 1'b0;
      m_addr[i]   = '0;
      m_wdata[i]  = '0;
      m_last[i]   = 1'b1;
      m_rdata[i][0] = '0;
      m_rdata[i][1] = '0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      int g;
      if (m_active[i]) begin
        if (m_k[i] == lat(i) - 1) begin
          m_active[i] = 1'b0;
          m_last[i]   = m_gid[i];
        end else begin
          if (m_k[i] == lat(i) - 2 && !m_rw[i]) m_rdata[i][m_gid[i]] = rdata_in[i];
          m_k[i]++;
        end
      end else begin
        g = -1;
        if (req[i][0] && req[i][1]) g = m_last[i] ? 0 : 1;
        else if (req[i][0])         g = 0;
        else if (req[i][1])         g = 1;
        if (g >= 0) begin
          m_active[i] = 1'b1;
          m_k[i]      = 0;
          m_gid[i]    = g[0];
          m_rw[i]     = rw_in[i][g];
          m_addr[i]   = addr_in[i][g];
          m_wdata[i]  = wdata_in[i][g];
        end
      end
    end
  endtask

  task automatic compare();
    for (int i = 0; i < NI; i++) begin
      bit done;
      done = m_active[i] && (m_k[i] == lat(i) - 1);
      chk("busy", i, 32'(busy[i]), 32'(m_active[i]));
      chk("bus_rw", i, 32'(bus_rw[i]), 32'(m_active[i] && m_rw[i]));
      chk("bus_addr", i, 32'(bus_addr[i]), 32'(m_addr[i]));
      chk("bus_wdata", i, 32'(bus_wdata[i]), 32'(m_wdata[i]));
      chk("grant_id", i, 32'(grant_id[i]), 32'(m_gid[i]));
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("m%0d_ack", m), i, 32'(ack[i][m]), 32'(done && (m_gid[i] == m[0])));
        chk($sformatf("m%0d_rdata", m), i, 32'(rdata[i][m]), 32'(m_rdata[i][m]));
      end
    end
  endtask

  // One clock: the model follows the edge, then outputs are checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  // Called at a falling edge: asserts reset mid-cycle and checks the asynchronous abort.
  task automatic reset_pulse();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_bus_rw", 0, 32'(bus_rw[0]), 32'd0);
    chk("rst_busy", 0, 32'(busy[0]), 32'd0);
    chk("rst_ack", 0, 32'({ack[0][1], ack[0][0]}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    compare();
    rst = 1'b0;
  endtask

  task automatic drive_random();
    for (int i = 0; i < NI; i++) begin
      for (int m = 0; m < 2; m++) begin
        bit inflight;
        bit acked;
        inflight = m_active[i] && (m_gid[i] == m[0]);
        acked    = inflight && (m_k[i] == lat(i) - 1);
        if (req[i][m] && inflight && !acked) begin
          req[i][m] = 1'b1;
        end else if (req[i][m] && !inflight) begin
          if ($urandom_range(0, 7) == 0) req[i][m] = 1'b0;
        end else begin
          req[i][m] = ($urandom_range(0, 2) != 0);
        end
        rw_in[i][m]    = 1'($urandom_range(0, 1));
        addr_in[i][m]  = ADDR_W'($urandom);
        wdata_in[i][m] = DATA_W'($urandom);
      end
      rdata_in[i] = DATA_W'($urandom);
    end
  endtask

  initial begin
    int acks;
    int since;
    int order[$];

    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      rdata_in[i] = '0;
      for (int m = 0; m < 2; m++) begin
        req[i][m]      = 1'b0;
        rw_in[i][m]    = 1'b0;
        addr_in[i][m]  = '0;
        wdata_in[i][m] = '0;
      end
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare();
    chk("reset_busy", 0, 32'(busy[0]), 32'd0);
    chk("reset_addr", 0, 32'(bus_addr[0]), 32'd0);
    chk("reset_grant", 0, 32'(grant_id[0]), 32'd0);
    rst = 1'b0;

    // m0 read of 0x123 on both instances; inst1 has no wait states.
    for (int i = 0; i < NI; i++) begin
      req[i][0]     = 1'b1;
      rw_in[i][0]   = RwRead;
      addr_in[i][0] = 11'h123;
      rdata_in[i]   = 4'hA;
    end
    tick();
    chk("t1_addr_c1", 0, 32'(bus_addr[0]), 32'h123);
    chk("t1_busy_c1", 0, 32'(busy[0]), 32'd1);
    tick();
    chk("t4_ack_c2", 1, 32'(ack[1][0]), 32'd1);
    chk("t4_rdata", 1, 32'(rdata[1][0]), 32'hA);
    req[1][0] = 1'b0;
    tick();
    chk("t1_noack_c3", 0, 32'(ack[0][0]), 32'd0);
    tick();
    chk("t1_ack_c4", 0, 32'(ack[0][0]), 32'd1);
    chk("t1_rdata", 0, 32'(rdata[0][0]), 32'hA);
    chk("t1_addr_c4", 0, 32'(bus_addr[0]), 32'h123);
    chk("t1_rw_c4", 0, 32'(bus_rw[0]), 32'd0);
    req[0][0] = 1'b0;
    tick();
    chk("t1_idle_c5", 0, 32'(busy[0]), 32'd0);

    // m1 write of 0x5 to 0x7FF.
    req[0][1]      = 1'b1;
    rw_in[0][1]    = RwWrite;
    addr_in[0][1]  = 11'h7FF;
    wdata_in[0][1] = 4'h5;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t2_rw", 0, 32'(bus_rw[0]), 32'd1);
      chk("t2_wdata", 0, 32'(bus_wdata[0]), 32'h5);
      if (ack[0][1] === 1'b1) begin
        acks++;
        req[0][1] = 1'b0;
      end
    end
    tick();
    chk("t2_rw_idle", 0, 32'(bus_rw[0]), 32'd0);
    chk("t2_ack_count", 0, 32'(acks), 32'd1);

    // Request fields changing after the grant must not reach the bus.
    req[0][0]      = 1'b1;
    rw_in[0][0]    = RwWrite;
    addr_in[0][0]  = 11'h2A5;
    wdata_in[0][0] = 4'hC;
    tick();
    addr_in[0][0]  = 11'h111;
    wdata_in[0][0] = 4'h3;
    rw_in[0][0]    = RwRead;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      chk("t6_addr", 0, 32'(bus_addr[0]), 32'h2A5);
      chk("t6_wdata", 0, 32'(bus_wdata[0]), 32'hC);
      chk("t6_rw", 0, 32'(bus_rw[0]), 32'd1);
    end
    req[0][0] = 1'b0;
    tick();

    // Reset during WAIT of an m1 write, then a tie right after release.
    req[0][1]      = 1'b1;
    rw_in[0][1]    = RwWrite;
    addr_in[0][1]  = 11'h03C;
    wdata_in[0][1] = 4'h9;
    tick();
    tick();
    chk("t5_rw_before", 0, 32'(bus_rw[0]), 32'd1);
    reset_pulse();
    req[0][0]     = 1'b1;
    rw_in[0][0]   = RwRead;
    addr_in[0][0] = 11'h100;
    rw_in[0][1]   = RwRead;
    addr_in[0][1] = 11'h200;
    since = -1;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      tick();
      if (since >= 0) since++;
      if (since == 1) chk("t3_idle_gap", 0, 32'(busy[0]), 32'd0);
      if (since == 2) chk("t3_regrant", 0, 32'(busy[0]), 32'd1);
      for (int m = 0; m < 2; m++) begin
        if (ack[0][m] === 1'b1) begin
          order.push_back(m);
          since = 0;
        end
      end
    end
    chk("t3_count", 0, 32'(order.size()), 32'd4);
    for (int n = 0; n < order.size(); n++) chk($sformatf("t3_order%0d", n), 0, 32'(order[n]), 32'(n % 2));
    req[0][0] = 1'b0;
    req[0][1] = 1'b0;
    tick();
    tick();
    chk("t3_quiet", 0, 32'(busy[0]), 32'd0);

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      if ($urandom_range(0, 199) == 0) begin
        reset_pulse();
      end else begin
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
